// File: rtl/adder_pkg.sv
// Shared definitions for the sequential adder/subtractor.
//   - state_e    : controller states
//   - DEF_WIDTH  : default operand width
//   - DEF_CHUNK  : default bits processed per clock
//   - signed_ovf : two's-complement overflow from operand/result sign bits
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // b_msb is the sign of the operand actually added (already inverted for subtract).
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_if.sv
// Handshake bundle between operand producer, adder and result consumer.
// Ports: clk, rst_n (carried for producer/consumer convenience).
// Request side : in_valid, in_ready, in_a, in_b, in_sub, in_acc.
// Result side  : out_valid, out_ready, out_y (WIDTH+1, top bit carry/borrow), out_ovf.
// Modports: master = producer/consumer view, slave = adder view.
interface adder_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic clk,
    input logic rst_n
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_y;
    logic             out_ovf;

    modport master (
        input  clk, rst_n, in_ready, out_valid, out_y, out_ovf,
        output in_valid, in_a, in_b, in_sub, in_acc, out_ready
    );

    modport slave (
        input  clk, rst_n, in_valid, in_a, in_b, in_sub, in_acc, out_ready,
        output in_ready, out_valid, out_y, out_ovf
    );

endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
// Ports: a, b (CHUNK), cin -> sum (CHUNK), cout.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock
// through a single reused adder_chunk slice, with an accumulator usable as operand A.
// Ports: clk, rst_n (async, active-low), bus (adder_if.slave: request and result
// valid/ready handshakes, out_y with carry/borrow in bit WIDTH, out_ovf).
// Optional: define ADDER_SEQ_SAT_EN to saturate the WIDTH-bit result on signed overflow.
// Constraints: WIDTH >= 2, WIDTH a multiple of CHUNK.
module adder_seq
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input logic   clk,
    input logic   rst_n,
    adder_if.slave bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q, acc_q;
    logic             carry_q, sub_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH:0]   y_q;
    logic             ovf_q;

    logic [CHUNK-1:0] ca, cb, cs;
    logic             cout;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] res_lo;
    logic             ovf;
    logic             last;
    logic             accept;
    logic             done_hs;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (ca),
        .b    (cb),
        .cin  (carry_q),
        .sum  (cs),
        .cout (cout)
    );

    assign accept  = (state_q == IDLE) && bus.in_valid;
    assign done_hs = (state_q == DONE) && bus.out_ready;
    assign last    = (k_q == KLAST);

    // Current chunk slice and the sum as it will look once this chunk is stored.
    always_comb begin
        ca       = a_q[k_q*CHUNK +: CHUNK];
        cb       = b_q[k_q*CHUNK +: CHUNK];
        sum_full = sum_q;
        sum_full[k_q*CHUNK +: CHUNK] = cs;
        ovf      = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_full[WIDTH-1]);
    end

`ifdef ADDER_SEQ_SAT_EN
    // Both operand signs agree on overflow, so A's sign gives the direction.
    always_comb begin
        res_lo = sum_full;
        if (ovf) begin
            res_lo = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_lo = sum_full;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            k_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.in_acc ? acc_q : bus.in_a;
                // Subtract as A + ~B + 1: inverted operand, carry-in of one.
                b_q     <= bus.in_b ^ {WIDTH{bus.in_sub}};
                carry_q <= bus.in_sub;
                sub_q   <= bus.in_sub;
                k_q     <= '0;
            end
            if (state_q == BUSY) begin
                sum_q   <= sum_full;
                carry_q <= cout;
                k_q     <= k_q + KW'(1);
                if (last) begin
                    // Borrow is the complement of the final carry.
                    y_q   <= {sub_q ? ~cout : cout, res_lo};
                    ovf_q <= ovf;
                end
            end
            if (done_hs) begin
                acc_q <= y_q[WIDTH-1:0];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = y_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
module tb_adder_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    adder_if #(.WIDTH(WIDTH)) bus (.clk(clk), .rst_n(rst_n));

    adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic acc);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_acc   = acc;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(guard < 50), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Count negedges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 50);
        check("out_valid_wait", 32'(lat < 50), 32'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic acc, input logic [16:0] exp_y,
                       input logic exp_ovf);
        int lat;
        send(a, b, sub, acc);
        wait_out(lat);
        check({tag, "_y"}, 32'(bus.out_y), 32'(exp_y));
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
        @(negedge clk);
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int stale;
        logic [16:0] exp_sat_pos;
        logic [16:0] exp_sat_neg;
        logic [16:0] exp_min_sum;

`ifdef ADDER_SEQ_SAT_EN
        exp_sat_pos = 17'h07FFF;
        exp_sat_neg = 17'h08000;
        exp_min_sum = 17'h18000;
`else
        exp_sat_pos = 17'h08000;
        exp_sat_neg = 17'h07FFF;
        exp_min_sum = 17'h10000;
`endif

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_y", 32'(bus.out_y), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        rst_n = 1'b1;

        // Accumulate from the reset value; in_a is noise
        run("acc1", 16'($urandom_range(0, 16'hFFFF)), 16'h0010, 1'b0, 1'b1, 17'h00010, 1'b0);
        run("acc2", 16'($urandom_range(0, 16'hFFFF)), 16'h0010, 1'b0, 1'b1, 17'h00020, 1'b0);
        run("acc3", 16'($urandom_range(0, 16'hFFFF)), 16'h0010, 1'b0, 1'b1, 17'h00030, 1'b0);
        run("acc4", 16'($urandom_range(0, 16'hFFFF)), 16'h0010, 1'b0, 1'b1, 17'h00040, 1'b0);

        // Carry out of full width, with latency
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        check("ffff_p1_latency", 32'(lat), 32'd5);
        check("ffff_p1_y", 32'(bus.out_y), 32'h10000);
        check("ffff_p1_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        check("ffff_p1_drop", 32'(bus.out_valid), 32'd0);

        run("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_sat_pos, 1'b1);
        run("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, 17'h1FFFE, 1'b0);
        run("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, exp_sat_neg, 1'b1);
        run("sub_plain", 16'h0005, 16'h0003, 1'b1, 1'b0, 17'h00002, 1'b0);
        run("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, exp_min_sum, 1'b1);

        // Back-pressure in DONE
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_out(lat);
        check("hold_y0", 32'(bus.out_y), 32'h02345);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'hAAAA;
        bus.in_b     = 16'h5555;
        bus.in_acc   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_y", 32'(bus.out_y), 32'h02345);
            check("hold_ovf", 32'(bus.out_ovf), 32'd0);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("release_idle", 32'(bus.in_ready), 32'd1);
        // Accumulator took the held result
        run("acc_after_hold", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 17'h02345, 1'b0);

        // Reset in the middle of BUSY (chunk 2)
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_y", 32'(bus.out_y), 32'd0);
        check("midrst_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);
        run("midrst_acc_zero", 16'h1357, 16'h0000, 1'b0, 1'b1, 17'h00000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised, multi-cycle adder/subtractor; successor to the fixed 4-bit combinational adder.
- Processes WIDTH-bit operands CHUNK bits per clock and reports carry/borrow and signed overflow.
- Has an internal accumulator and valid/ready handshakes on both sides.
- Sits between a stimulus/operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 16: operand width in bits; must be ≥ 2.
- CHUNK, 4: bits processed per cycle; WIDTH mod CHUNK = 0; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand request.
- in_a  in  WIDTH  operand A; ignored when in_acc=1.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_acc  in  1  1 = use accumulator as operand A.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub).
- out_ovf  out  1  two's-complement signed overflow of the WIDTH-bit result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_y=0, out_ovf=0, accumulator=0.
  - Any in-flight operation is discarded; no output is produced for it.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. When in_valid=1 the request is accepted. The block latches A, B^{WIDTH{in_sub}}, carry=in_sub and chunk counter=0, then goes to BUSY.
  - BUSY: in_ready=0. Each cycle adds chunk k (bits k*CHUNK+:CHUNK) with the running carry, stores the sum chunk, updates the carry and increments k. After chunk NCHUNK−1 it goes to DONE.
  - DONE: out_valid=1. out_y and out_ovf are held stable while out_ready=0. On out_valid & out_ready the accumulator loads out_y[WIDTH-1:0] and the FSM returns to IDLE.
- Latency:
  - The request handshake occurs in cycle 0; out_valid=1 first in cycle NCHUNK+1.
  - Minimum spacing between accepted requests is NCHUNK+2 cycles.
- No overlap: in_valid is ignored outside IDLE. The producer must hold its request stable until in_ready=1.
- Arithmetic:
  - out_y[WIDTH-1:0] = A ± B mod 2^WIDTH.
  - Add: out_y[WIDTH] = carry out.
  - Sub: out_y[WIDTH] = borrow = NOT final carry, i.e. 1 when A < B unsigned.
  - out_ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), where B' is the inverted operand for subtract.
- Accumulate mode: with in_acc=1, A = accumulator value at the acceptance edge. The accumulator is only cleared by reset.
- out_valid drops in the cycle after the output handshake. out_y keeps its last value until the next DONE.

Optional Feature:
- Macro: ADDER_SEQ_SAT_EN.
- Defined:
  - When out_ovf=1, out_y[WIDTH-1:0] saturates: positive overflow gives 0x7F..F, negative overflow gives 0x80..0.
  - Carry/borrow bit and out_ovf are unchanged.
  - The accumulator loads the saturated value.
- Undefined: results wrap; no saturation logic is present.

Decomposition:
- Package adder_pkg:
  - state enum typedef (IDLE, BUSY, DONE).
  - Default WIDTH/CHUNK localparams.
  - Function for the signed-overflow calculation.
- Sub-module adder_chunk: combinational CHUNK-bit slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout.
  - Instanced once and reused each BUSY cycle.
- The adder_if interface gains clk/rst_n plus handshake signals, with widths parametrised by WIDTH.

Test Plan (WIDTH=16, CHUNK=4):
- 0xFFFF + 0x0001, out_ready=1 → out_y=0x10000, out_ovf=0, out_valid rises exactly in cycle 5 after the handshake.
- 0x7FFF + 0x0001 → out_y=0x08000, out_ovf=1. With ADDER_SEQ_SAT_EN: out_y=0x07FFF.
- Sub 0x0003 − 0x0005 → out_y=0x1FFFE (borrow=1), out_ovf=0. Sub 0x8000 − 0x0001 → out_y=0x07FFF, out_ovf=1.
- After reset, four requests in_acc=1, in_b=0x0010, add → results 0x0010, 0x0020, 0x0030, 0x0040; in_a is randomised and ignored.
- Hold out_ready=0 for 3 cycles in DONE → out_y/out_ovf stable, in_ready=0, and a new in_valid is not accepted. Release → IDLE next cycle.
- Assert rst_n=0 mid-BUSY (chunk 2) → outputs are immediately at reset values, accumulator=0, and no stale out_valid appears after reset is released.
